multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Main controller that sequences the shared multicycle RISC-V datapath: one memory port, one ALU, the register file and the immediate sign-extend unit. It decodes the latched instruction, walks a Moore state machine through fetch, decode, execute, memory and writeback, and drives every datapath select and write enable. Datapath select and immediate-type outputs are combinational decodes of the state and opcode.

## Interface
Parameters:
- none. Encodings are fixed in the shared package.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction register and OldPC enable.
- result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
- alu_src_b  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- imm_src  out  2  sign-extend type: 00 I, 01 S, 10 B, 11 J.
- reg_write  out  1  register file write enable.
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

## Operation
States and their asserted outputs; unlisted outputs are 0.

- **FETCH**
  - Outputs: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_update=1.
  - Next: DECODE.
- **DECODE**
  - Outputs: alu_src_a=01, alu_src_b=01, alu_op=00. This precomputes the branch/jump target.
  - Next, by opcode:
    - 0000011 (lw) or 0100011 (sw) → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1100011 → BEQ.
    - 1101111 → JAL.
    - Any other opcode → FETCH, with illegal=1 in this cycle.
- **MEMADR**
  - Outputs: alu_src_a=10, alu_src_b=01, alu_op=00.
  - Next: MEMREAD if lw, MEMWRITE if sw.
- **MEMREAD**
  - Outputs: result_src=00, adr_src=1.
  - Next: MEMWB.
- **MEMWB**
  - Outputs: result_src=01, reg_write=1.
  - Next: FETCH.
- **MEMWRITE**
  - Outputs: result_src=00, adr_src=1, mem_write=1.
  - Next: FETCH.
- **EXECUTER**
  - Outputs: alu_src_a=10, alu_src_b=00, alu_op=10.
  - Next: ALUWB.
- **EXECUTEI**
  - Outputs: alu_src_a=10, alu_src_b=01, alu_op=10.
  - Next: ALUWB.
- **JAL**
  - Outputs: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1.
  - Next: ALUWB.
- **ALUWB**
  - Outputs: result_src=00, reg_write=1.
  - Next: FETCH.
- **BEQ**
  - Outputs: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1.
  - Next: FETCH.

Derived signals:
- pc_write = pc_update | (branch & zero).
- imm_src is decoded from op and is independent of state:
  - lw → 00, sw → 01, beq → 10, jal → 11.
  - R-type, I-type ALU and illegal → 00.
- ALU decoder:
  - alu_op 00 → add.
  - alu_op 01 → sub.
  - alu_op 10, by funct3:
    - 000 → sub if op[5] & funct7b5, else add.
    - 010 → slt.
    - 110 → or.
    - 111 → and.
    - Any other funct3 → add.

## Timing
- Reset:
  - State register loads FETCH on the first rising edge with rst=1.
  - While rst=1, pc_write, ir_write, reg_write, mem_write and illegal are forced to 0.
  - Other outputs show their FETCH values.
  - Reset asserted mid-instruction aborts it: the next state is FETCH, and no write enable is asserted while rst is high.
- Instruction latency, counted from FETCH:
  - lw: 5 cycles.
  - sw, R-type, I-type, jal: 4 cycles.
  - beq: 3 cycles.
- No stalls or handshakes: memory is single-cycle.
- beq:
  - zero is sampled combinationally in the BEQ cycle.
  - pc_write asserts in that same cycle only if zero=1.
- op, funct3 and funct7b5 are stable from the cycle after FETCH until the next FETCH, because the IR is written only in FETCH.
- illegal is Moore-on-DECODE with an opcode check. It is high for exactly one cycle, and the state returns to FETCH without any write.

## Structure
- Shared package holds:
  - state encoding (11 states, 4-bit);
  - opcode constants;
  - imm_src, alu_src_a/b, result_src and alu_control encodings.
- Sub-modules:
  - alu_decoder: combinational; inputs alu_op, funct3, funct7b5, op[5]; output alu_control.
  - State register, next-state logic and output decode stay in the top module.

## Test plan
- Reset with rst=1 for 2 cycles, then release → state FETCH, ir_write=1, pc_write=1 in the first post-reset cycle, no writes during reset.
- lw x6,-4(x9), instruction 0xFFC4A303 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; imm_src=00; reg_write=1 only in cycle 5 with result_src=01.
- sw x6,8(x9), instruction 0x0064A423 → 4 cycles; imm_src=01; mem_write=1 only in MEMWRITE with adr_src=1.
- Two ALU instructions:
  - or x4,x5,x6 (0x0062E233) → alu_control=011 in EXECUTER, ALUWB writes.
  - sub, with funct7b5=1 and funct3=000 → alu_control=001.
- beq, instruction 0xFE420AE3:
  - zero=1 → pc_write=1 in cycle 3.
  - zero=0 → pc_write=0 in cycle 3.
  - Both cases: imm_src=10, and the next state is FETCH.
- Opcode 0x7F → illegal=1 pulse in DECODE, next state FETCH, no write enable asserted.
- rst asserted during MEMREAD → next state FETCH, reg_write never asserted.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm_pkg
//
// Purpose:
//   Shared encodings for the multicycle RISC-V controller:
//   - controller state encoding;
//   - the opcodes it understands;
//   - datapath select codes and ALU control codes.
//   The controller and its ALU decoder both import this package so that the
//   encodings live in exactly one place.
//
// Contents:
//   state_t            11-state controller encoding (4 bits)
//   OP_*               supported 7-bit opcodes
//   IMM_*              sign-extend unit type select
//   SRCA_* / SRCB_*    ALU operand selects
//   RES_*              result multiplexer select
//   ALUOP_*            ALU operation class from controller to ALU decoder
//   ALU_*              final ALU control codes
//   is_supported_op()  opcode legality helper
// ---------------------------------------------------------------------------
package multicycle_control_fsm_pkg;

   // Controller states. FETCH is encoded as zero so a cleared register
   // already points at the start of an instruction.
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_JAL      = 4'd8,
      S_ALUWB    = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   // Supported opcodes (instr[6:0]).
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   // Sign-extend unit type select.
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // ALU operand A select.
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   // ALU operand B select.
   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result multiplexer select.
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // Operation class handed from the controller to the ALU decoder.
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Final ALU control codes.
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // True for every opcode DECODE knows how to dispatch.
   function automatic logic is_supported_op(input logic [6:0] op);
      return (op == OP_LW)    || (op == OP_SW)    ||
             (op == OP_RTYPE) || (op == OP_ITYPE) ||
             (op == OP_BEQ)   || (op == OP_JAL);
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm_alu_decoder
//
// Purpose:
//   Turns the controller's ALU operation class plus the instruction function
//   fields into the final ALU control code. Purely combinational.
//
// Ports:
//   alu_op       in   2  operation class: add, sub or "use funct fields"
//   funct3       in   3  instr[14:12]
//   funct7b5     in   1  instr[30]
//   op5          in   1  instr[5], separates R-type from I-type ALU ops
//   alu_control  out  3  ALU control code
// ---------------------------------------------------------------------------
module multicycle_control_fsm_alu_decoder
   import multicycle_control_fsm_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_control
);

   // funct7b5 only selects subtract for register-register ops. An addi whose
   // immediate happens to have bit 10 set must still add, hence the op5 gate.
   always_comb begin
      alu_control = ALU_ADD;
      unique case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            unique case (funct3)
               3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Purpose:
//   Main controller of the shared multicycle RISC-V datapath. A Moore state
//   machine walks each instruction through fetch, decode, execute, memory
//   and writeback and drives every datapath select and write enable.
//   Supported instructions: lw, sw, R-type ALU, I-type ALU, beq and jal.
//
// Ports:
//   clk          in   1  clock, rising edge
//   rst          in   1  synchronous active-high reset
//   op           in   7  instr[6:0]
//   funct3       in   3  instr[14:12]
//   funct7b5     in   1  instr[30]
//   zero         in   1  ALU zero flag
//   pc_write     out  1  PC register enable
//   adr_src      out  1  memory address select (0 PC, 1 ALUOut)
//   mem_write    out  1  data memory write enable
//   ir_write     out  1  IR / OldPC enable
//   result_src   out  2  result select (ALUOut, Data, ALUResult)
//   alu_src_a    out  2  ALU A select (PC, OldPC, RD1)
//   alu_src_b    out  2  ALU B select (RD2, ImmExt, 4)
//   alu_control  out  3  ALU operation
//   imm_src      out  2  sign-extend type
//   reg_write    out  1  register file write enable
//   illegal      out  1  one-cycle pulse on an unsupported opcode in DECODE
// ---------------------------------------------------------------------------
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic [1:0] imm_src,
   output logic       reg_write,
   output logic       illegal
);

   state_t state;
   state_t next_state;

   // State the output decode looks at. While reset is high the outputs show
   // FETCH values regardless of what the register holds.
   state_t out_state;

   logic       pc_update;
   logic       branch;
   logic [1:0] alu_op;
   logic       raw_mem_write;
   logic       raw_ir_write;
   logic       raw_reg_write;

   // State register. Reset always returns to FETCH, which also aborts any
   // instruction that was in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. DECODE dispatches on the opcode latched in FETCH;
   // anything unknown drops straight back to FETCH.
   always_comb begin
      next_state = S_FETCH;
      unique case (state)
         S_FETCH: next_state = S_DECODE;
         S_DECODE: begin
            unique case (op)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_RTYPE:     next_state = S_EXECUTER;
               OP_ITYPE:     next_state = S_EXECUTEI;
               OP_BEQ:       next_state = S_BEQ;
               OP_JAL:       next_state = S_JAL;
               default:      next_state = S_FETCH;
            endcase
         end
         S_MEMADR:   next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  next_state = S_MEMWB;
         S_MEMWB:    next_state = S_FETCH;
         S_MEMWRITE: next_state = S_FETCH;
         S_EXECUTER: next_state = S_ALUWB;
         S_EXECUTEI: next_state = S_ALUWB;
         S_JAL:      next_state = S_ALUWB;
         S_ALUWB:    next_state = S_FETCH;
         S_BEQ:      next_state = S_FETCH;
         default:    next_state = S_FETCH;
      endcase
   end

   // Moore output decode. Every output starts at zero / its 00 code and each
   // state raises only what it needs. Write enables are collected as raw_*
   // terms so reset can mask them in one place below.
   always_comb begin
      out_state     = rst ? S_FETCH : state;
      pc_update     = 1'b0;
      branch        = 1'b0;
      adr_src       = 1'b0;
      raw_mem_write = 1'b0;
      raw_ir_write  = 1'b0;
      raw_reg_write = 1'b0;
      result_src    = RES_ALUOUT;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_RD2;
      alu_op        = ALUOP_ADD;
      unique case (out_state)
         S_FETCH: begin
            raw_ir_write = 1'b1;
            alu_src_a    = SRCA_PC;
            alu_src_b    = SRCB_FOUR;
            alu_op       = ALUOP_ADD;
            result_src   = RES_ALURESULT;
            pc_update    = 1'b1;
         end
         // Target = OldPC + imm is computed here so BEQ and JAL can use it.
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_ADD;
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_ADD;
         end
         S_MEMREAD: begin
            result_src = RES_ALUOUT;
            adr_src    = 1'b1;
         end
         S_MEMWB: begin
            result_src    = RES_DATA;
            raw_reg_write = 1'b1;
         end
         S_MEMWRITE: begin
            result_src    = RES_ALUOUT;
            adr_src       = 1'b1;
            raw_mem_write = 1'b1;
         end
         S_EXECUTER: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_RD2;
            alu_op    = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
         end
         // PC takes the target held in ALUOut while the ALU forms OldPC + 4
         // as the link value written back in ALUWB.
         S_JAL: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            alu_op     = ALUOP_ADD;
            result_src = RES_ALUOUT;
            pc_update  = 1'b1;
         end
         S_ALUWB: begin
            result_src    = RES_ALUOUT;
            raw_reg_write = 1'b1;
         end
         S_BEQ: begin
            alu_src_a  = SRCA_RD1;
            alu_src_b  = SRCB_RD2;
            alu_op     = ALUOP_SUB;
            result_src = RES_ALUOUT;
            branch     = 1'b1;
         end
         default: begin
            alu_src_a = SRCA_PC;
         end
      endcase
   end

   // Write enables and the illegal pulse are suppressed while reset is high,
   // so an aborted instruction can never commit anything.
   assign pc_write  = !rst && (pc_update || (branch && zero));
   assign mem_write = !rst && raw_mem_write;
   assign ir_write  = !rst && raw_ir_write;
   assign reg_write = !rst && raw_reg_write;
   assign illegal   = !rst && (state == S_DECODE) && !is_supported_op(op);

   // Immediate type follows the opcode alone, independent of state.
   always_comb begin
      imm_src = IMM_I;
      unique case (op)
         OP_SW:   imm_src = IMM_S;
         OP_BEQ:  imm_src = IMM_B;
         OP_JAL:  imm_src = IMM_J;
         default: imm_src = IMM_I;
      endcase
   end

   multicycle_control_fsm_alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (op[5]),
      .alu_control (alu_control)
   );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Purpose:
//   Self-checking bench for multicycle_control_fsm. Each instruction is
//   described as the list of control words it must produce cycle by cycle,
//   built from the instruction type, and compared every cycle against the
//   DUT outputs. Fixed directed instructions come first, then a randomized
//   stream that also injects occasional mid-instruction resets.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

   // Packed view of every controller output, most significant first.
   typedef struct packed {
      logic       pc_write;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
      logic [1:0] imm_src;
      logic       reg_write;
      logic       illegal;
   } ctrl_t;

   logic       clk;
   logic       rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       pc_write;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_control;
   logic [1:0] imm_src;
   logic       reg_write;
   logic       illegal;

   ctrl_t observed;

   int vectors;
   int miscompares;

   multicycle_control_fsm dut (
      .clk         (clk),
      .rst         (rst),
      .op          (op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .zero        (zero),
      .pc_write    (pc_write),
      .adr_src     (adr_src),
      .mem_write   (mem_write),
      .ir_write    (ir_write),
      .result_src  (result_src),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_control (alu_control),
      .imm_src     (imm_src),
      .reg_write   (reg_write),
      .illegal     (illegal)
   );

   assign observed = '{pc_write, adr_src, mem_write, ir_write, result_src,
                       alu_src_a, alu_src_b, alu_control, imm_src,
                       reg_write, illegal};

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference ALU control: operation class plus function fields.
   function automatic logic [2:0] refAluControl(input logic [1:0] aluOp);
      if (aluOp == 2'b00) return 3'b000;
      if (aluOp == 2'b01) return 3'b001;
      case (funct3)
         3'b000:  return (op[5] && funct7b5) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // Reference immediate type, from the opcode only.
   function automatic logic [1:0] refImm();
      case (op)
         7'b0100011: return 2'b01;
         7'b1100011: return 2'b10;
         7'b1101111: return 2'b11;
         default:    return 2'b00;
      endcase
   endfunction

   // One expected control word, written as the table row for a step.
   function automatic ctrl_t word(input logic pcw, input logic adr,
                                  input logic mw, input logic irw,
                                  input logic [1:0] rs, input logic [1:0] sa,
                                  input logic [1:0] sb, input logic [1:0] aluOp,
                                  input logic rw, input logic ill);
      return '{pcw, adr, mw, irw, rs, sa, sb, refAluControl(aluOp), refImm(),
               rw, ill};
   endfunction

   function automatic logic legalOp(input logic [6:0] o);
      return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
             o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
   endfunction

   // Outputs seen while reset is high: FETCH selects, no write enables.
   function automatic ctrl_t resetWord();
      return word(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
   endfunction

   task automatic checkOutput(input string tag, input ctrl_t got,
                              input ctrl_t want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("[TB] FAIL %s: got %05h (pcw%b adr%b mw%b irw%b rs%b sa%b sb%b alu%b imm%b rw%b ill%b) expected %05h (pcw%b adr%b mw%b irw%b rs%b sa%b sb%b alu%b imm%b rw%b ill%b)",
                  tag, got, got.pc_write, got.adr_src, got.mem_write,
                  got.ir_write, got.result_src, got.alu_src_a, got.alu_src_b,
                  got.alu_control, got.imm_src, got.reg_write, got.illegal,
                  want, want.pc_write, want.adr_src, want.mem_write,
                  want.ir_write, want.result_src, want.alu_src_a,
                  want.alu_src_b, want.alu_control, want.imm_src,
                  want.reg_write, want.illegal);
      end
   endtask

   // Runs one instruction starting in FETCH. abortAt (1-based cycle) raises
   // reset during that cycle, checks the masked outputs and releases reset
   // after one edge; 0 means run to completion.
   task automatic applyStimulus(input string name, input logic [31:0] instr,
                                input logic z, input int abortAt);
      ctrl_t exp[$];
      op       = instr[6:0];
      funct3   = instr[14:12];
      funct7b5 = instr[30];
      zero     = z;

      exp.push_back(word(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0));
      exp.push_back(word(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0,
                         !legalOp(op)));
      case (op)
         7'b0000011: begin
            exp.push_back(word(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0));
            exp.push_back(word(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
            exp.push_back(word(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0));
         end
         7'b0100011: begin
            exp.push_back(word(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0));
            exp.push_back(word(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
         end
         7'b0110011: begin
            exp.push_back(word(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0));
            exp.push_back(word(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
         end
         7'b0010011: begin
            exp.push_back(word(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0));
            exp.push_back(word(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
         end
         7'b1101111: begin
            exp.push_back(word(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0));
            exp.push_back(word(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
         end
         7'b1100011: begin
            exp.push_back(word(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0));
         end
         default: begin
         end
      endcase

      for (int i = 0; i < exp.size(); i++) begin
         if (abortAt == i + 1) begin
            rst = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("%s abort c%0d", name, i + 1), observed,
                        resetWord());
            @(posedge clk);
            #1;
            rst = 1'b0;
            return;
         end
         @(negedge clk);
         checkOutput($sformatf("%s c%0d", name, i + 1), observed, exp[i]);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [31:0] instr;
      logic [6:0]  badOp;
      int          kind;
      vectors     = 0;
      miscompares = 0;
      rst      = 1'b1;
      op       = 7'b0000011;
      funct3   = 3'b010;
      funct7b5 = 1'b0;
      zero     = 1'b0;

      // Two reset cycles: FETCH selects visible, all writes held off.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checkOutput($sformatf("reset c%0d", i + 1), observed, resetWord());
         @(posedge clk);
      end
      #1;
      rst = 1'b0;

      applyStimulus("lw",      32'hFFC4A303, 1'b0, 0);
      applyStimulus("sw",      32'h0064A423, 1'b1, 0);
      applyStimulus("or",      32'h0062E233, 1'b0, 0);
      applyStimulus("sub",     32'h40628233, 1'b0, 0);
      applyStimulus("addi7b5", 32'h40028213, 1'b0, 0);
      applyStimulus("slti",    32'h0052A213, 1'b0, 0);
      applyStimulus("and",     32'h0062F233, 1'b1, 0);
      applyStimulus("beq z1",  32'hFE420AE3, 1'b1, 0);
      applyStimulus("beq z0",  32'hFE420AE3, 1'b0, 0);
      applyStimulus("jal",     32'h008000EF, 1'b0, 0);
      applyStimulus("illegal", 32'h0000007F, 1'b0, 0);
      applyStimulus("lw abort",32'hFFC4A303, 1'b1, 4);
      applyStimulus("lw after",32'hFFC4A303, 1'b0, 0);

      // Randomized instruction stream with occasional reset aborts.
      for (int n = 0; n < 120; n++) begin
         instr = $urandom;
         kind  = $urandom_range(0, 6);
         case (kind)
            0: instr[6:0] = 7'b0000011;
            1: instr[6:0] = 7'b0100011;
            2: instr[6:0] = 7'b0110011;
            3: instr[6:0] = 7'b0010011;
            4: instr[6:0] = 7'b1100011;
            5: instr[6:0] = 7'b1101111;
            default: begin
               badOp = 7'($urandom);
               while (legalOp(badOp)) badOp = 7'($urandom);
               instr[6:0] = badOp;
            end
         endcase
         applyStimulus($sformatf("rnd%0d op%02h", n, instr[6:0]), instr,
                       1'($urandom),
                       ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 5)) : 0);
      end

      // Closing instruction confirms the stream ended back in FETCH.
      applyStimulus("final", 32'h0062E233, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors,
               miscompares);
      $finish;
   end

endmodule
